seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants for the multiplexed seven-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   localparam int CA_DP      = 7;
   localparam int CA_SEG_MSB = 6;

   localparam logic [7:0] CA_OFF     = 8'hFF;
   localparam logic [7:0] CA_DP_ONLY = ~(8'(1) << CA_DP);

   // Active-low g..a patterns, entry 15 first so SEG_TABLE[n] selects nibble n.
   localparam logic [15:0][CA_SEG_MSB:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic [3:0] nibble;
      logic       dp;
      logic       blank;
      logic       lz_sup;
   } digit_sel_t;

   function automatic logic [7:0] ca_pattern(input logic [CA_SEG_MSB:0] seg_n,
                                             input logic              dp);
      return {~dp, seg_n};
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Hex nibble to active-low seven-segment pattern (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0]          nibble,
   output logic [CA_SEG_MSB:0] seg_n
);

   assign seg_n = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Time-multiplexed seven-segment driver with frame-atomic updates,
//            leading-zero suppression and PWM brightness.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_CYCLES = 10000,
   parameter int BRIGHT_W       = 4
)(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*NUM_DIGITS-1:0] DIGITS,
   input  logic [NUM_DIGITS-1:0]   DP_EN,
   input  logic [NUM_DIGITS-1:0]   BLANK,
   input  logic                    LZ_EN,
   input  logic [BRIGHT_W-1:0]     BRIGHT,
   input  logic                    LOAD,
   output logic [7:0]              CA,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [2:0]              DIGIT_IDX,
   output logic                    FRAME_DONE
);

   localparam int               CNT_W      = $clog2(REFRESH_CYCLES);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
         $error("seg7_scan: NUM_DIGITS must be within 1..8");
      end
      if (REFRESH_CYCLES < 2) begin : g_bad_refresh
         $error("seg7_scan: REFRESH_CYCLES must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0]        dwell_cnt;
   logic [BRIGHT_W-1:0]     pwm_cnt;
   logic [2:0]              idx;
   logic                    dwell_last;
   logic                    frame_last;

   logic [4*NUM_DIGITS-1:0] pend_digits;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic                    pend_lz;
   logic [4*NUM_DIGITS-1:0] act_digits;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic [NUM_DIGITS-1:0]   act_blank;
   logic                    act_lz;

   logic [NUM_DIGITS-1:0]   lz_sup;
   logic                    zero_run;
   digit_sel_t              sel;
   logic [CA_SEG_MSB:0]     seg_n;
   logic                    pwm_on;
   logic                    lit;
   logic [7:0]              ca_next;
   logic [NUM_DIGITS-1:0]   an_next;

   assign dwell_last = (dwell_cnt == DWELL_LAST);
   assign frame_last = dwell_last && (idx == IDX_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         dwell_cnt <= '0;
         idx       <= '0;
         pwm_cnt   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
         if (dwell_last) begin
            dwell_cnt <= '0;
            idx       <= frame_last ? 3'd0 : idx + 3'd1;
         end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
         end
      end
   end

   // Active set only changes on the wrap edge; a LOAD on that same edge lands
   // in pending and is picked up one frame later.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_blank  <= '0;
         pend_lz     <= 1'b0;
         act_digits  <= '0;
         act_dp      <= '0;
         act_blank   <= '0;
         act_lz      <= 1'b0;
      end else begin
         if (LOAD) begin
            pend_digits <= DIGITS;
            pend_dp     <= DP_EN;
            pend_blank  <= BLANK;
            pend_lz     <= LZ_EN;
         end
         if (frame_last) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_lz     <= pend_lz;
         end
      end
   end

   // A digit is suppressed when it and every digit above it is zero.
   always_comb begin
      zero_run = 1'b1;
      lz_sup   = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run  = zero_run && (act_digits[4*k +: 4] == 4'd0);
         lz_sup[k] = act_lz && zero_run;
      end
   end

   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k)) begin
            sel.nibble = act_digits[4*k +: 4];
            sel.dp     = act_dp[k];
            sel.blank  = act_blank[k];
            sel.lz_sup = lz_sup[k];
         end
      end
   end

   seg7_decode u_decode (
      .nibble (sel.nibble),
      .seg_n  (seg_n)
   );

   assign pwm_on = (&BRIGHT) || (pwm_cnt < BRIGHT);

   always_comb begin
      ca_next = ca_pattern(seg_n, sel.dp);
      lit     = 1'b1;
      if (sel.blank) begin
         ca_next = CA_OFF;
         lit     = 1'b0;
      end else if (sel.lz_sup) begin
         ca_next = sel.dp ? CA_DP_ONLY : CA_OFF;
         lit     = sel.dp;
      end
      an_next = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k) && lit && pwm_on) begin
            an_next[k] = 1'b0;
         end
      end
   end

   // FRAME_DONE is registered alongside DIGIT_IDX so it marks the last output
   // cycle of the final digit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         CA         <= CA_OFF;
         AN         <= '1;
         DIGIT_IDX  <= 3'd0;
         FRAME_DONE <= 1'b0;
      end else begin
         CA         <= ca_next;
         AN         <= an_next;
         DIGIT_IDX  <= idx;
         FRAME_DONE <= frame_last;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Directed self-checking bench for seg7_scan (8-digit and 4-digit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

   localparam int N     = 8;
   localparam int R     = 16;
   localparam int FRAME = N * R;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int total = 0;
   int bad   = 0;

   logic        rst, lz_en, load;
   logic [31:0] digits;
   logic [7:0]  dp_en, blank;
   logic [3:0]  bright;
   logic [7:0]  ca, an;
   logic [2:0]  digit_idx;
   logic        frame_done;

   logic [15:0] digits4;
   logic [3:0]  dp4, blank4, bright4, an4;
   logic        lz4, load4;
   logic [7:0]  ca4;
   logic [2:0]  idx4;
   logic        fd4;

   seg7_scan #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BRIGHT_W(4)) dut (
      .CLK(clk), .RST(rst), .DIGITS(digits), .DP_EN(dp_en), .BLANK(blank),
      .LZ_EN(lz_en), .BRIGHT(bright), .LOAD(load), .CA(ca), .AN(an),
      .DIGIT_IDX(digit_idx), .FRAME_DONE(frame_done)
   );

   seg7_scan #(.NUM_DIGITS(4), .REFRESH_CYCLES(3), .BRIGHT_W(4)) dut4 (
      .CLK(clk), .RST(rst), .DIGITS(digits4), .DP_EN(dp4), .BLANK(blank4),
      .LZ_EN(lz4), .BRIGHT(bright4), .LOAD(load4), .CA(ca4), .AN(an4),
      .DIGIT_IDX(idx4), .FRAME_DONE(fd4)
   );

   logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic logic [7:0] exp_ca(input logic [3:0] nib, input logic dp);
      return dp ? (seg_ref[nib] & 8'h7F) : seg_ref[nib];
   endfunction

   logic [7:0] ca_s [N];
   logic [7:0] an_s [N];
   logic [2:0] ix_s [N];
   int         fd_cnt, oh_bad;
   logic       fd_end;

   // Steps one frame from a FRAME_DONE sample point, optionally pulsing LOAD.
   task automatic run_frame(input logic [31:0] v1, input int c1,
                            input logic [31:0] v2, input int c2);
      fd_cnt = 0;
      oh_bad = 0;
      for (int cyc = 1; cyc <= FRAME; cyc++) begin
         @(negedge clk);
         if (cyc == c1) begin
            digits = v1; load = 1'b1;
         end else if (cyc == c2) begin
            digits = v2; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         if (frame_done) fd_cnt++;
         if ($countones(~an) > 1) oh_bad++;
         if ((cyc - 1) % R == R / 2) begin
            ca_s[(cyc - 1) / R] = ca;
            an_s[(cyc - 1) / R] = an;
            ix_s[(cyc - 1) / R] = digit_idx;
         end
      end
      fd_end = frame_done;
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 3 * FRAME);
      total++;
      if (!frame_done) begin
         bad++;
         $display("FAIL wait_frame: frame_done=%b after %0d cycles, want 1", frame_done, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; digits = '0; dp_en = '0; blank = '0; lz_en = 1'b0; bright = 4'hF;
      repeat (3) @(negedge clk);
      total++; if (ca !== 8'hFF) begin bad++; $display("FAIL reset_ca: got %h want ff", ca); end
      total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an: got %h want ff", an); end
      total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (ca !== 8'hC0) begin bad++; $display("FAIL post_reset_ca: got %h want c0", ca); end
      total++; if (an !== 8'hFE) begin bad++; $display("FAIL post_reset_an: got %h want fe", an); end
      total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL post_reset_idx: got %0d want 0", digit_idx); end
   endtask

   task automatic test_digits();
      logic [31:0] x;
      x = 32'h7841_2A0F;
      dp_en = '0; blank = '0; lz_en = 1'b0; bright = 4'hF;
      wait_frame();
      run_frame(x, 5, '0, -1);
      run_frame('0, -1, '0, -1);
      for (int k = 0; k < N; k++) begin
         total++;
         if (ca_s[k] !== exp_ca(x[4*k +: 4], 1'b0)) begin
            bad++; $display("FAIL digits_ca[%0d]: got %h want %h", k, ca_s[k], exp_ca(x[4*k +: 4], 1'b0));
         end
         total++;
         if (an_s[k] !== ~(8'h01 << k)) begin
            bad++; $display("FAIL digits_an[%0d]: got %h want %h", k, an_s[k], ~(8'h01 << k));
         end
         total++;
         if (ix_s[k] !== 3'(k)) begin
            bad++; $display("FAIL digits_idx[%0d]: got %0d want %0d", k, ix_s[k], k);
         end
      end
      total++; if (oh_bad != 0) begin bad++; $display("FAIL digits_onehot: got %0d bad cycles want 0", oh_bad); end
   endtask

   task automatic test_load_mid();
      logic [31:0] ld1 [5] = '{32'h1234_5678, 32'h0000_00AB, 32'h1111_1111, 32'h0, 32'h0};
      int          c1  [5] = '{3 * R + 5, 10, FRAME - 1, -1, -1};
      logic [31:0] ld2 [5] = '{32'h0, 32'hFEDC_BA98, 32'h0, 32'h0, 32'h0};
      int          c2  [5] = '{-1, 50, -1, -1, -1};
      logic [31:0] shown [5] = '{32'h7841_2A0F, 32'h1234_5678, 32'hFEDC_BA98,
                                 32'hFEDC_BA98, 32'h1111_1111};
      for (int f = 0; f < 5; f++) begin
         run_frame(ld1[f], c1[f], ld2[f], c2[f]);
         for (int k = 0; k < N; k++) begin
            total++;
            if (ca_s[k] !== exp_ca(shown[f][4*k +: 4], 1'b0)) begin
               bad++; $display("FAIL load_f%0d_ca[%0d]: got %h want %h", f, k, ca_s[k],
                               exp_ca(shown[f][4*k +: 4], 1'b0));
            end
         end
         total++; if (fd_cnt != 1) begin bad++; $display("FAIL load_f%0d_fd_count: got %0d want 1", f, fd_cnt); end
         total++; if (fd_end !== 1'b1) begin bad++; $display("FAIL load_f%0d_fd_end: got %b want 1", f, fd_end); end
      end
   endtask

   task automatic test_lz();
      logic [31:0] sc_dig [3] = '{32'h0000_0050, 32'h0000_0000, 32'h1234_5678};
      logic [7:0]  sc_dp  [3] = '{8'h08, 8'h00, 8'h02};
      logic [7:0]  sc_bl  [3] = '{8'h00, 8'h00, 8'h01};
      logic        sc_lz  [3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0]  e_ca [3][N] = '{
         '{8'hC0, 8'h92, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
         '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
         '{8'hFF, 8'h78, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}};
      logic [7:0]  e_an [3][N] = '{
         '{8'hFE, 8'hFD, 8'hFF, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
         '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
         '{8'hFF, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F}};
      for (int s = 0; s < 3; s++) begin
         dp_en = sc_dp[s]; blank = sc_bl[s]; lz_en = sc_lz[s];
         run_frame(sc_dig[s], 5, '0, -1);
         run_frame('0, -1, '0, -1);
         for (int k = 0; k < N; k++) begin
            total++;
            if (ca_s[k] !== e_ca[s][k]) begin
               bad++; $display("FAIL lz_s%0d_ca[%0d]: got %h want %h", s, k, ca_s[k], e_ca[s][k]);
            end
            total++;
            if (an_s[k] !== e_an[s][k]) begin
               bad++; $display("FAIL lz_s%0d_an[%0d]: got %h want %h", s, k, an_s[k], e_an[s][k]);
            end
         end
      end
   endtask

   task automatic test_bright();
      int on16, on128, oh, on_zero;
      dp_en = '0; blank = '0; lz_en = 1'b0; bright = 4'hF;
      run_frame(32'h1234_5678, 5, '0, -1);
      run_frame('0, -1, '0, -1);
      bright = 4'd4;
      repeat (2) @(negedge clk);
      on16 = 0; on128 = 0; oh = 0;
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         if (an !== 8'hFF) begin
            on128++;
            if (c < 16) on16++;
         end
         if ($countones(~an) > 1) oh++;
      end
      total++; if (on16 != 4) begin bad++; $display("FAIL bright4_16: got %0d active want 4", on16); end
      total++; if (on128 != 32) begin bad++; $display("FAIL bright4_128: got %0d active want 32", on128); end
      total++; if (oh != 0) begin bad++; $display("FAIL bright_onehot: got %0d bad cycles want 0", oh); end
      bright = 4'd0;
      repeat (2) @(negedge clk);
      on_zero = 0;
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         if (an !== 8'hFF) on_zero++;
      end
      total++; if (on_zero != 0) begin bad++; $display("FAIL bright0: got %0d active want 0", on_zero); end
      bright = 4'hF;
   endtask

   task automatic test_dut4();
      int         e;
      logic [3:0] ea;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 13; j++) begin
         @(negedge clk);
         e  = (j / 3) % 4;
         ea = ~(4'b0001 << e);
         total++;
         if (idx4 !== 3'(e)) begin bad++; $display("FAIL d4_idx[%0d]: got %0d want %0d", j, idx4, e); end
         total++;
         if (an4 !== ea) begin bad++; $display("FAIL d4_an[%0d]: got %h want %h", j, an4, ea); end
         total++;
         if (fd4 !== (j == 11)) begin bad++; $display("FAIL d4_fd[%0d]: got %b want %b", j, fd4, (j == 11)); end
      end
      total++; if (ca4 !== 8'hC0) begin bad++; $display("FAIL d4_ca: got %h want c0", ca4); end
   endtask

   task automatic test_reset_mid();
      int guard, dwell;
      guard = 0;
      while (cyc_cnt < 25000 && guard < 60000) begin
         @(negedge clk);
         guard++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (an !== 8'hFF) begin bad++; $display("FAIL rmid_an: got %h want ff", an); end
      total++; if (ca !== 8'hFF) begin bad++; $display("FAIL rmid_ca: got %h want ff", ca); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rmid_fd: got %b want 0", frame_done); end
      @(negedge clk);
      total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL rmid_idx0: got %0d want 0", digit_idx); end
      total++; if (ca !== 8'hC0) begin bad++; $display("FAIL rmid_ca0: got %h want c0", ca); end
      total++; if (an !== 8'hFE) begin bad++; $display("FAIL rmid_an0: got %h want fe", an); end
      dwell = 1;
      for (int c = 0; c < 4 * R; c++) begin
         @(negedge clk);
         if (digit_idx !== 3'd0) break;
         dwell++;
      end
      total++; if (dwell != R) begin bad++; $display("FAIL rmid_dwell: got %0d want %0d", dwell, R); end
      total++; if (digit_idx !== 3'd1) begin bad++; $display("FAIL rmid_idx1: got %0d want 1", digit_idx); end
      total++; if (ca !== 8'hC0) begin bad++; $display("FAIL rmid_ca1: got %h want c0", ca); end
   endtask

   initial begin
      digits4 = '0; dp4 = '0; blank4 = '0; lz4 = 1'b0; load4 = 1'b0; bright4 = 4'hF;
      test_reset();
      test_digits();
      test_load_mid();
      test_lz();
      test_bright();
      test_dut4();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
